// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Holds the FSM state encoding and the frame geometry constants.
// Imported by the loader top level and its word assembler.
package prog_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_WIDTH      = 16;

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// master = byte source / memory sink side, slave = the loader itself.
// A byte moves when rx_valid && rx_ready; imem_we is a one-cycle strobe.
interface prog_loader_if;

  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/prog_loader_word_assembler.sv
// Packs bytes MSB-first into 32-bit words and flags each completed word.
// Latency: word_vld/word_dat valid the cycle after the 4th byte is accepted.
// No backpressure of its own: it takes a byte whenever byte_vld is high.
module word_assembler
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_vld,
  input  logic [7:0]  byte_dat,
  output logic        word_last,
  output logic        word_vld,
  output logic [31:0] word_dat
);

  logic [31:0] sh_q, sh_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        word_vld_q, word_vld_d;

  // The byte being accepted this cycle completes a word.
  assign word_last = byte_vld && (cnt_q == 2'(BYTES_PER_WORD - 1));

  // Shift in the accepted byte and raise word_vld for the following cycle.
  always_comb begin
    sh_d       = sh_q;
    cnt_d      = cnt_q;
    word_vld_d = 1'b0;
    if (clr) begin
      sh_d  = '0;
      cnt_d = '0;
    end else if (byte_vld) begin
      sh_d       = {sh_q[23:0], byte_dat};
      cnt_d      = cnt_q + 2'd1;
      word_vld_d = word_last;
    end
  end

  // Assembler state registers; a reset drops any partial word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_q       <= '0;
      cnt_q      <= '0;
      word_vld_q <= 1'b0;
    end else begin
      sh_q       <= sh_d;
      cnt_q      <= cnt_d;
      word_vld_q <= word_vld_d;
    end
  end

  // In the strobe cycle the shift register holds exactly the completed word.
  assign word_vld = word_vld_q;
  assign word_dat = sh_q;

endmodule

// File: rtl/prog_loader.sv
// Loads a length/data/XOR-checksum byte frame into instruction memory, holding the core in reset.
// Latency: imem write strobe one cycle after a word's 4th byte; done/cpu_hold one cycle after CHK.
// Accepts a byte every cycle while loading; rx_ready is low only in DONE/ERR until start.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic           clk,
  input  logic           rst,
  prog_loader_if.slave   bus,
  input  logic           start,
  output logic           cpu_hold,
  output logic           done,
  output logic           err
);

  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_WORDS);

  state_t               state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] idx_q, idx_d;
  logic [7:0]           xor_q, xor_d;
  logic [31:0]          addr_q, addr_d;

  logic                 xfer;
  logic                 asm_clr;
  logic                 byte_vld;
  logic                 word_last;
  logic                 word_vld;
  logic [31:0]          word_dat;
  logic [LEN_WIDTH-1:0] len_full;

  assign bus.rx_ready = (state_q != S_DONE) && (state_q != S_ERR);
  assign xfer         = bus.rx_valid && bus.rx_ready;
  assign len_full     = {len_q[15:8], bus.rx_data};

  word_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .clr       (asm_clr),
    .byte_vld  (byte_vld),
    .byte_dat  (bus.rx_data),
    .word_last (word_last),
    .word_vld  (word_vld),
    .word_dat  (word_dat)
  );

  // Frame-parsing FSM: length, data words with running XOR, checksum, then park.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    idx_d    = idx_q;
    xor_d    = xor_q;
    addr_d   = addr_q;
    asm_clr  = 1'b0;
    byte_vld = 1'b0;
    case (state_q)
      S_LEN_HI: begin
        if (xfer) begin
          len_d   = {bus.rx_data, 8'h00};
          xor_d   = xor_q ^ bus.rx_data;
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d = len_full;
          xor_d = xor_q ^ bus.rx_data;
          if (len_full == '0) begin
            state_d = S_CHK;
          end else if (len_full > MAX_LEN) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        byte_vld = xfer;
        if (xfer) begin
          xor_d = xor_q ^ bus.rx_data;
          // Address is latched here so it is stable for the whole strobe cycle.
          if (word_last) begin
            addr_d = BASE_ADDR + {14'b0, idx_q, 2'b00};
            idx_d  = idx_q + 16'd1;
            if (idx_q + 16'd1 == len_q) begin
              state_d = S_CHK;
            end
          end
        end
      end
      S_CHK: begin
        if (xfer) begin
          state_d = (bus.rx_data == xor_q) ? S_DONE : S_ERR;
        end
      end
      S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN_HI;
          idx_d   = '0;
          xor_d   = '0;
          addr_d  = BASE_ADDR;
          asm_clr = 1'b1;
        end
      end
      default: state_d = S_LEN_HI;
    endcase
  end

  // FSM and datapath registers; reset returns to a fresh, unloaded state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_LEN_HI;
      len_q   <= '0;
      idx_q   <= '0;
      xor_q   <= '0;
      addr_q  <= BASE_ADDR;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      xor_q   <= xor_d;
      addr_q  <= addr_d;
    end
  end

  assign bus.imem_we    = word_vld;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = word_dat;
  assign done           = (state_q == S_DONE);
  assign err            = (state_q == S_ERR);
  assign cpu_hold       = (state_q != S_DONE);

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: two instances (base 0x0 and base 0x400).
// Expected memory writes are queued as frames are driven and checked as strobes appear.
// Status outputs are checked at fixed points one tick after the clock edge.
module tb_prog_loader;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start0 = 1'b0, start1 = 1'b0;
  logic hold0, done0, err0;
  logic hold1, done1, err1;

  int n_chk  = 0;
  int n_fail = 0;
  int nwr0   = 0;
  int nwr1   = 0;
  logic we_prev0 = 1'b0, we_prev1 = 1'b0;

  logic [63:0] q0[$];
  logic [63:0] q1[$];
  logic [31:0] wbuf [8];

  prog_loader_if bus0 ();
  prog_loader_if bus1 ();

  prog_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(256)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave), .start(start0),
    .cpu_hold(hold0), .done(done0), .err(err0)
  );

  prog_loader #(.BASE_ADDR(32'h0000_0400), .MAX_WORDS(256)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave), .start(start1),
    .cpu_hold(hold1), .done(done1), .err(err1)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Write-strobe scoreboard for instance 0.
  always @(negedge clk) begin
    if (bus0.imem_we === 1'b1) begin
      logic [63:0] e;
      chk("wr0_single_cycle", {31'b0, we_prev0}, 32'd0);
      chk("wr0_hold_high", {31'b0, hold0}, 32'd1);
      chk("wr0_pending", {31'b0, q0.size() > 0}, 32'd1);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("wr0_addr", bus0.imem_addr, e[63:32]);
        chk("wr0_data", bus0.imem_wdata, e[31:0]);
      end
      nwr0++;
    end
    we_prev0 = bus0.imem_we;
  end

  // Write-strobe scoreboard for instance 1.
  always @(negedge clk) begin
    if (bus1.imem_we === 1'b1) begin
      logic [63:0] e;
      chk("wr1_single_cycle", {31'b0, we_prev1}, 32'd0);
      chk("wr1_hold_high", {31'b0, hold1}, 32'd1);
      chk("wr1_pending", {31'b0, q1.size() > 0}, 32'd1);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("wr1_addr", bus1.imem_addr, e[63:32]);
        chk("wr1_data", bus1.imem_wdata, e[31:0]);
      end
      nwr1++;
    end
    we_prev1 = bus1.imem_we;
  end

  function automatic logic rdy(input int sel);
    return (sel == 0) ? bus0.rx_ready : bus1.rx_ready;
  endfunction

  task automatic drive(input int sel, input logic v, input logic [7:0] d);
    if (sel == 0) begin
      bus0.rx_valid = v;
      bus0.rx_data  = d;
    end else begin
      bus1.rx_valid = v;
      bus1.rx_data  = d;
    end
  endtask

  // Present one byte and return one tick after the edge that transferred it.
  // rx_valid is left high so consecutive calls stream a byte per cycle.
  task automatic send(input int sel, input logic [7:0] b, input bit gap, input bit rdychk);
    bit got;
    if (gap) begin
      drive(sel, 1'b0, 8'h00);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    drive(sel, 1'b1, b);
    if (rdychk) chk("rx_ready_in_frame", {31'b0, rdy(sel)}, 32'd1);
    got = 1'b0;
    for (int t = 0; t < 50; t++) begin
      if (rdy(sel)) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!got) chk("rx_ready_timeout", {31'b0, rdy(sel)}, 32'd1);
    else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input int sel, input int n, input bit bad, input bit gap, input bit rdychk);
    logic [7:0]  x, b;
    logic [15:0] nn;
    logic [31:0] base, w;
    nn   = 16'(n);
    base = (sel == 0) ? 32'h0000_0000 : 32'h0000_0400;
    x    = nn[15:8] ^ nn[7:0];
    send(sel, nn[15:8], gap, rdychk);
    send(sel, nn[7:0], gap, rdychk);
    for (int i = 0; i < n; i++) begin
      w = wbuf[i];
      if (sel == 0) q0.push_back({base + 32'(4 * i), w});
      else          q1.push_back({base + 32'(4 * i), w});
      for (int k = 3; k >= 0; k--) begin
        b = w[8*k +: 8];
        x = x ^ b;
        send(sel, b, gap, rdychk);
      end
    end
    send(sel, bad ? (x ^ 8'h01) : x, gap, rdychk);
    drive(sel, 1'b0, 8'h00);
  endtask

  task automatic pulse_start(input int sel);
    if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic check_reset0(input string tag);
    chk({tag, "_rx_ready"}, {31'b0, bus0.rx_ready}, 32'd1);
    chk({tag, "_hold"},     {31'b0, hold0}, 32'd1);
    chk({tag, "_we"},       {31'b0, bus0.imem_we}, 32'd0);
    chk({tag, "_addr"},     bus0.imem_addr, 32'h0000_0000);
    chk({tag, "_wdata"},    bus0.imem_wdata, 32'h0000_0000);
    chk({tag, "_done"},     {31'b0, done0}, 32'd0);
    chk({tag, "_err"},      {31'b0, err0}, 32'd0);
  endtask

  initial begin
    int w0;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    #12;
    check_reset0("reset0");
    chk("reset1_addr", bus1.imem_addr, 32'h0000_0400);
    chk("reset1_hold", {31'b0, hold1}, 32'd1);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // Single word 00 01 20 08 00 05 2C, with exact strobe timing.
    q0.push_back({32'h0, 32'h2008_0005});
    send(0, 8'h00, 0, 0);
    send(0, 8'h01, 0, 0);
    send(0, 8'h20, 0, 0);
    send(0, 8'h08, 0, 0);
    send(0, 8'h00, 0, 0);
    chk("t1_no_early_we", {31'b0, bus0.imem_we}, 32'd0);
    send(0, 8'h05, 0, 0);
    chk("t1_we_latency", {31'b0, bus0.imem_we}, 32'd1);
    chk("t1_addr", bus0.imem_addr, 32'h0);
    chk("t1_wdata", bus0.imem_wdata, 32'h2008_0005);
    chk("t1_hold_before_chk", {31'b0, hold0}, 32'd1);
    send(0, 8'h2C, 0, 0);
    drive(0, 1'b0, 8'h00);
    chk("t1_done", {31'b0, done0}, 32'd1);
    chk("t1_hold", {31'b0, hold0}, 32'd0);
    chk("t1_err", {31'b0, err0}, 32'd0);
    chk("t1_rx_ready", {31'b0, bus0.rx_ready}, 32'd0);
    chk("t1_writes", 32'(nwr0), 32'd1);
    pulse_start(0);
    chk("t1_restart_done", {31'b0, done0}, 32'd0);
    chk("t1_restart_hold", {31'b0, hold0}, 32'd1);
    chk("t1_restart_ready", {31'b0, bus0.rx_ready}, 32'd1);

    // Three words back-to-back with rx_ready checked on every byte.
    wbuf[0] = 32'h2001_000A;
    wbuf[1] = 32'h2002_0014;
    wbuf[2] = 32'hAC01_0004;
    w0 = nwr0;
    send_frame(0, 3, 0, 0, 1);
    @(posedge clk);
    #1;
    chk("t2_done", {31'b0, done0}, 32'd1);
    chk("t2_writes", 32'(nwr0 - w0), 32'd3);
    chk("t2_q_empty", 32'(q0.size()), 32'd0);
    pulse_start(0);

    // Bad checksum 00 01 20 08 00 05 2D: write still happens, then error.
    wbuf[0] = 32'h2008_0005;
    w0 = nwr0;
    send_frame(0, 1, 1, 0, 0);
    chk("t3_err", {31'b0, err0}, 32'd1);
    chk("t3_hold", {31'b0, hold0}, 32'd1);
    chk("t3_rx_ready", {31'b0, bus0.rx_ready}, 32'd0);
    chk("t3_done", {31'b0, done0}, 32'd0);
    chk("t3_writes", 32'(nwr0 - w0), 32'd1);
    pulse_start(0);
    chk("t3_restart_err", {31'b0, err0}, 32'd0);
    chk("t3_restart_ready", {31'b0, bus0.rx_ready}, 32'd1);

    // Length 0x0101 exceeds MAX_WORDS: error right after LEN_LO.
    w0 = nwr0;
    send(0, 8'h01, 0, 0);
    send(0, 8'h01, 0, 0);
    drive(0, 1'b0, 8'h00);
    chk("t4_err", {31'b0, err0}, 32'd1);
    chk("t4_rx_ready", {31'b0, bus0.rx_ready}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("t4_writes", 32'(nwr0 - w0), 32'd0);
    pulse_start(0);

    // Zero-length frame 00 00 00: done without writes.
    send(0, 8'h00, 0, 0);
    send(0, 8'h00, 0, 0);
    send(0, 8'h00, 0, 0);
    drive(0, 1'b0, 8'h00);
    chk("t5_done", {31'b0, done0}, 32'd1);
    chk("t5_hold", {31'b0, hold0}, 32'd0);
    chk("t5_writes", 32'(nwr0 - w0), 32'd0);
    pulse_start(0);

    // Reset while the 3rd byte of word 1 is on the bus.
    w0 = nwr0;
    q0.push_back({32'h0, 32'h1111_2222});
    send(0, 8'h00, 0, 0);
    send(0, 8'h02, 0, 0);
    send(0, 8'h11, 0, 0);
    send(0, 8'h11, 0, 0);
    send(0, 8'h22, 0, 0);
    send(0, 8'h22, 0, 0);
    send(0, 8'h33, 0, 0);
    send(0, 8'h44, 0, 0);
    drive(0, 1'b1, 8'h55);
    #2 rst = 1'b0;
    #1;
    check_reset0("t6_async");
    drive(0, 1'b0, 8'h00);
    @(posedge clk);
    #3 rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_reset0("t6_after");
    chk("t6_writes", 32'(nwr0 - w0), 32'd1);
    wbuf[0] = 32'h0123_4567;
    wbuf[1] = 32'h89AB_CDEF;
    send_frame(0, 2, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("t6_reload_done", {31'b0, done0}, 32'd1);
    chk("t6_reload_writes", 32'(nwr0 - w0), 32'd3);

    // Random rx_valid gaps on the 0x400-based instance, four words.
    wbuf[0] = 32'h1234_5678;
    wbuf[1] = 32'hDEAD_BEEF;
    wbuf[2] = 32'h0000_0001;
    wbuf[3] = 32'hFFFF_FF00;
    send_frame(1, 4, 0, 1, 0);
    @(posedge clk);
    #1;
    chk("t7_done", {31'b0, done1}, 32'd1);
    chk("t7_hold", {31'b0, hold1}, 32'd0);
    chk("t7_writes", 32'(nwr1), 32'd4);

    repeat (3) @(posedge clk);
    #1;
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
